// File: rtl/wb_intercon_pkg.sv
// Shared constants for the single-master Wishbone interconnect: slave indices,
// address windows, FSM encoding and the timeout error word.
package wb_intercon_pkg;

    localparam int NS = 5;

    localparam int SLV_ROM   = 0;
    localparam int SLV_UART  = 1;
    localparam int SLV_GPIO  = 2;
    localparam int SLV_CLINT = 3;
    localparam int SLV_PLIC  = 4;

    localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
    localparam logic [31:0] ROM_MASK   = 32'hFFFF_0000;
    localparam logic [31:0] UART_BASE  = 32'h1000_0000;
    localparam logic [31:0] UART_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] GPIO_BASE  = 32'h1000_1000;
    localparam logic [31:0] GPIO_MASK  = 32'hFFFF_F000;
    localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
    localparam logic [31:0] CLINT_MASK = 32'hFFFF_0000;
    localparam logic [31:0] PLIC_BASE  = 32'h0C00_0000;
    localparam logic [31:0] PLIC_MASK  = 32'hFC00_0000;

    // Element k of these packed tables belongs to slave index k.
    localparam logic [NS-1:0][31:0] SLV_BASE =
        {PLIC_BASE, CLINT_BASE, GPIO_BASE, UART_BASE, ROM_BASE};
    localparam logic [NS-1:0][31:0] SLV_MASK =
        {PLIC_MASK, CLINT_MASK, GPIO_MASK, UART_MASK, ROM_MASK};

    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    // Keep only the lowest set bit so overlapping windows resolve to the lowest index.
    function automatic logic [NS-1:0] first_hit(input logic [NS-1:0] hits);
        return hits & (~hits + 1'b1);
    endfunction

endpackage

// File: rtl/wb_intercon_if.sv
// Bundle of the upstream (core) and downstream (peripheral) Wishbone signals.
// The interconnect is a slave to the core and a master to the peripherals.
interface wb_intercon_if;
    import wb_intercon_pkg::*;

    logic [31:0]      m_adr_i;
    logic [31:0]      m_dat_i;
    logic [3:0]       m_sel_i;
    logic             m_we_i;
    logic             m_stb_i;
    logic             m_cyc_i;
    logic [31:0]      m_dat_o;
    logic             m_ack_o;
    logic             m_err_o;

    logic [31:0]      s_adr_o;
    logic [31:0]      s_dat_o;
    logic [3:0]       s_sel_o;
    logic             s_we_o;
    logic [NS-1:0]    s_stb_o;
    logic [NS-1:0]    s_cyc_o;
    logic [NS*32-1:0] s_dat_i;
    logic [NS-1:0]    s_ack_i;

    modport slave (
        input  m_adr_i, m_dat_i, m_sel_i, m_we_i, m_stb_i, m_cyc_i,
        output m_dat_o, m_ack_o, m_err_o
    );

    modport master (
        output s_adr_o, s_dat_o, s_sel_o, s_we_o, s_stb_o, s_cyc_o,
        input  s_dat_i, s_ack_i
    );

endinterface

// File: rtl/wb_addr_decode.sv
// Combinational address decoder: one-hot slave select plus a miss flag.
module wb_addr_decode
    import wb_intercon_pkg::*;
(
    input  logic [31:0]   adr,
    output logic [NS-1:0] onehot,
    output logic          miss
);

    logic [NS-1:0] hit;

    always_comb begin
        hit = '0;
        for (int k = 0; k < NS; k++) begin
            hit[k] = ((adr & SLV_MASK[k]) == SLV_BASE[k]);
        end
        onehot = first_hit(hit);
        miss   = ~|hit;
    end

endmodule

// File: rtl/wb_intercon.sv
// Single-master, five-slave Wishbone classic interconnect with registered
// request, one-hot slave strobes, decode-miss error and ack watchdog.
module wb_intercon
    import wb_intercon_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input logic          wb_clk_i,
    input logic          wb_rst_i,
    wb_intercon_if.slave  core,
    wb_intercon_if.master periph
);

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic [15:0]   timer_q, timer_d;
    logic [NS-1:0] stb_q, stb_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   wdat_q, wdat_d;
    logic [3:0]    sel_q, sel_d;
    logic          we_q, we_d;
    logic [31:0]   rdat_q, rdat_d;
    logic          ack_q, ack_d;
    logic          err_q, err_d;

    logic [NS-1:0] dec_onehot;
    logic          dec_miss;
    logic          sel_ack;
    logic [31:0]   sel_dat;
    logic          req;

    wb_addr_decode u_decode (
        .adr    (core.m_adr_i),
        .onehot (dec_onehot),
        .miss   (dec_miss)
    );

    // Only the strobed slave's ack and data are visible; strays are masked off.
    always_comb begin
        sel_ack = |(periph.s_ack_i & stb_q);
        sel_dat = '0;
        for (int k = 0; k < NS; k++) begin
            if (stb_q[k]) begin
                sel_dat = sel_dat | periph.s_dat_i[32*k +: 32];
            end
        end
    end

    // A response pulse on the bus blocks a new request for that cycle.
    assign req = core.m_cyc_i & core.m_stb_i & ~ack_q & ~err_q;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        stb_d   = stb_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        rdat_d  = rdat_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req) begin
                    if (dec_miss) begin
                        err_d  = 1'b1;
                        rdat_d = '0;
                    end else begin
                        adr_d   = core.m_adr_i;
                        wdat_d  = core.m_dat_i;
                        sel_d   = core.m_sel_i;
                        we_d    = core.m_we_i;
                        stb_d   = dec_onehot;
                        timer_d = '0;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!core.m_cyc_i) begin
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (sel_ack) begin
                    if (!we_q) begin
                        rdat_d = sel_dat;
                    end
                    ack_d   = 1'b1;
                    stb_d   = '0;
                    state_d = IDLE;
                end else if (timer_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    rdat_d  = ERR_DATA;
                    stb_d   = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            default: begin
                stb_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            stb_q   <= '0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            rdat_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            stb_q   <= stb_d;
            adr_q   <= adr_d;
            wdat_q  <= wdat_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            rdat_q  <= rdat_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
    end

    assign core.m_dat_o   = rdat_q;
    assign core.m_ack_o   = ack_q;
    assign core.m_err_o   = err_q;
    assign periph.s_adr_o = adr_q;
    assign periph.s_dat_o = wdat_q;
    assign periph.s_sel_o = sel_q;
    assign periph.s_we_o  = we_q;
    assign periph.s_stb_o = stb_q;
    assign periph.s_cyc_o = stb_q;

endmodule

// File: tb/tb_wb_intercon.sv
// Directed bench for wb_intercon: reads, writes, decode miss, timeout,
// abort, stray ack, mid-transaction reset and back-to-back transfers.
module tb_wb_intercon;
    import wb_intercon_pkg::*;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;

    wb_intercon_if bus ();

    wb_intercon #(.TIMEOUT(16)) dut (
        .wb_clk_i (clk),
        .wb_rst_i (rst),
        .core     (bus),
        .periph   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "time limit");
    end

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic bus_idle();
        bus.m_adr_i = '0;
        bus.m_dat_i = '0;
        bus.m_sel_i = '0;
        bus.m_we_i  = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.m_cyc_i = 1'b0;
        bus.s_ack_i = '0;
    endtask

    task automatic request(input logic [31:0] adr, input logic [31:0] dat,
                           input logic [3:0] sel, input logic we);
        bus.m_adr_i = adr;
        bus.m_dat_i = dat;
        bus.m_sel_i = sel;
        bus.m_we_i  = we;
        bus.m_stb_i = 1'b1;
        bus.m_cyc_i = 1'b1;
    endtask

    task automatic test_reset();
        bus_idle();
        bus.s_dat_i = '0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL rst_ack: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b want 0", bus.m_err_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_err++; $display("FAIL rst_dat: got %h want 0", bus.m_dat_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL rst_stb: got %b want 00000", bus.s_stb_o); end
        n_chk++; if (bus.s_cyc_o !== 5'b0) begin n_err++; $display("FAIL rst_cyc: got %b want 00000", bus.s_cyc_o); end
        n_chk++; if (bus.s_adr_o !== 32'h0) begin n_err++; $display("FAIL rst_adr: got %h want 0", bus.s_adr_o); end
    endtask

    task automatic test_clint_read();
        request(32'h0200_BFF8, 32'h0, 4'hF, 1'b0);
        step();
        n_chk++; if (bus.s_stb_o !== 5'b01000) begin n_err++; $display("FAIL crd_stb: got %b want 01000", bus.s_stb_o); end
        n_chk++; if (bus.s_cyc_o !== 5'b01000) begin n_err++; $display("FAIL crd_cyc: got %b want 01000", bus.s_cyc_o); end
        step();
        bus.s_ack_i = 5'b01000;
        bus.s_dat_i[32*SLV_CLINT +: 32] = 32'h0000_0123;
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL crd_early_ack: got %b want 0", bus.m_ack_o); end
        step();
        bus.s_ack_i = '0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_ack_o !== 1'b1) begin n_err++; $display("FAIL crd_ack: got %b want 1", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0000_0123) begin n_err++; $display("FAIL crd_dat: got %h want 00000123", bus.m_dat_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL crd_stb_drop: got %b want 00000", bus.s_stb_o); end
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL crd_ack_pulse: got %b want 0", bus.m_ack_o); end
    endtask

    task automatic test_clint_write();
        request(32'h0200_4000, 32'h0000_0400, 4'hF, 1'b1);
        step();
        n_chk++; if (bus.s_adr_o !== 32'h0200_4000) begin n_err++; $display("FAIL cwr_adr: got %h want 02004000", bus.s_adr_o); end
        n_chk++; if (bus.s_dat_o !== 32'h0000_0400) begin n_err++; $display("FAIL cwr_dat: got %h want 00000400", bus.s_dat_o); end
        n_chk++; if (bus.s_sel_o !== 4'hF) begin n_err++; $display("FAIL cwr_sel: got %h want f", bus.s_sel_o); end
        n_chk++; if (bus.s_we_o !== 1'b1) begin n_err++; $display("FAIL cwr_we: got %b want 1", bus.s_we_o); end
        n_chk++; if (bus.s_stb_o !== 5'b01000) begin n_err++; $display("FAIL cwr_stb: got %b want 01000", bus.s_stb_o); end
        bus.s_ack_i = 5'b01000;
        bus.s_dat_i[32*SLV_CLINT +: 32] = 32'h7777_7777;
        step();
        bus.s_ack_i = '0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_ack_o !== 1'b1) begin n_err++; $display("FAIL cwr_ack: got %b want 1", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL cwr_err: got %b want 0", bus.m_err_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0000_0123) begin n_err++; $display("FAIL cwr_dat_held: got %h want 00000123", bus.m_dat_o); end
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL cwr_ack_pulse: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL cwr_err_after: got %b want 0", bus.m_err_o); end
    endtask

    task automatic test_decode_miss();
        request(32'h8000_0000, 32'h0, 4'hF, 1'b0);
        step();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_err_o !== 1'b1) begin n_err++; $display("FAIL miss_err: got %b want 1", bus.m_err_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_err++; $display("FAIL miss_dat: got %h want 0", bus.m_dat_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL miss_stb: got %b want 00000", bus.s_stb_o); end
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL miss_ack: got %b want 0", bus.m_ack_o); end
        step();
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL miss_err_pulse: got %b want 0", bus.m_err_o); end
    endtask

    task automatic test_timeout();
        int high_cycles;
        int early_resp;
        high_cycles = 0;
        early_resp  = 0;
        request(32'h1000_0010, 32'h0, 4'hF, 1'b0);
        for (int i = 0; i < 16; i++) begin
            step();
            if (bus.s_stb_o == 5'b00010) high_cycles++;
            if (bus.m_err_o || bus.m_ack_o) early_resp++;
        end
        n_chk++; if (high_cycles !== 16) begin n_err++; $display("FAIL tmo_stb_cycles: got %0d want 16", high_cycles); end
        n_chk++; if (early_resp !== 0) begin n_err++; $display("FAIL tmo_early_resp: got %0d want 0", early_resp); end
        step();
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_err_o !== 1'b1) begin n_err++; $display("FAIL tmo_err: got %b want 1", bus.m_err_o); end
        n_chk++; if (bus.m_dat_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL tmo_dat: got %h want deadbeef", bus.m_dat_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL tmo_stb_drop: got %b want 00000", bus.s_stb_o); end
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL tmo_ack: got %b want 0", bus.m_ack_o); end
        step();
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL tmo_err_pulse: got %b want 0", bus.m_err_o); end
    endtask

    task automatic test_abort();
        request(32'h1000_1004, 32'h0, 4'hF, 1'b0);
        step();
        n_chk++; if (bus.s_stb_o !== 5'b00100) begin n_err++; $display("FAIL abt_stb: got %b want 00100", bus.s_stb_o); end
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        bus.s_ack_i = 5'b00100;
        bus.s_dat_i[32*SLV_GPIO +: 32] = 32'h5555_5555;
        step();
        bus.s_ack_i = '0;
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL abt_ack: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL abt_err: got %b want 0", bus.m_err_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL abt_stb_drop: got %b want 00000", bus.s_stb_o); end
        n_chk++; if (bus.m_dat_o !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL abt_dat_held: got %h want deadbeef", bus.m_dat_o); end
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL abt_ack_late: got %b want 0", bus.m_ack_o); end
    endtask

    task automatic test_stray_ack();
        request(32'h0000_0100, 32'h0, 4'hF, 1'b0);
        step();
        n_chk++; if (bus.s_stb_o !== 5'b00001) begin n_err++; $display("FAIL stray_stb: got %b want 00001", bus.s_stb_o); end
        bus.s_ack_i = 5'b00010;
        bus.s_dat_i[32*SLV_UART +: 32] = 32'h1111_1111;
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL stray_ack: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.s_stb_o !== 5'b00001) begin n_err++; $display("FAIL stray_stb_hold: got %b want 00001", bus.s_stb_o); end
        bus.s_ack_i = 5'b00001;
        bus.s_dat_i[32*SLV_ROM +: 32] = 32'hAAAA_0001;
        step();
        bus.s_ack_i = '0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_ack_o !== 1'b1) begin n_err++; $display("FAIL stray_rom_ack: got %b want 1", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'hAAAA_0001) begin n_err++; $display("FAIL stray_rom_dat: got %h want aaaa0001", bus.m_dat_o); end
        step();
    endtask

    task automatic test_reset_mid();
        request(32'h0C00_0004, 32'h1234_5678, 4'h3, 1'b1);
        step();
        n_chk++; if (bus.s_stb_o !== 5'b10000) begin n_err++; $display("FAIL rmid_stb: got %b want 10000", bus.s_stb_o); end
        rst = 1'b1;
        bus.s_ack_i = 5'b10000;
        step();
        rst = 1'b0;
        bus.s_ack_i = '0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL rmid_stb_drop: got %b want 00000", bus.s_stb_o); end
        n_chk++; if (bus.s_cyc_o !== 5'b0) begin n_err++; $display("FAIL rmid_cyc: got %b want 00000", bus.s_cyc_o); end
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL rmid_ack: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0) begin n_err++; $display("FAIL rmid_mdat: got %h want 0", bus.m_dat_o); end
        n_chk++; if (bus.s_dat_o !== 32'h0) begin n_err++; $display("FAIL rmid_sdat: got %h want 0", bus.s_dat_o); end
        n_chk++; if (bus.s_sel_o !== 4'h0) begin n_err++; $display("FAIL rmid_sel: got %h want 0", bus.s_sel_o); end
        n_chk++; if (bus.s_we_o !== 1'b0) begin n_err++; $display("FAIL rmid_we: got %b want 0", bus.s_we_o); end
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL rmid_ack_late: got %b want 0", bus.m_ack_o); end
    endtask

    task automatic test_back_to_back();
        request(32'h1000_1008, 32'h0, 4'hF, 1'b0);
        step();
        n_chk++; if (bus.s_stb_o !== 5'b00100) begin n_err++; $display("FAIL b2b_stb1: got %b want 00100", bus.s_stb_o); end
        bus.s_ack_i = 5'b00100;
        bus.s_dat_i[32*SLV_GPIO +: 32] = 32'h0000_0B0B;
        step();
        n_chk++; if (bus.m_ack_o !== 1'b1) begin n_err++; $display("FAIL b2b_ack1: got %b want 1", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0000_0B0B) begin n_err++; $display("FAIL b2b_dat1: got %h want 00000b0b", bus.m_dat_o); end
        bus.s_ack_i = '0;
        bus.m_adr_i = 32'h0000_0200;
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL b2b_gap_ack: got %b want 0", bus.m_ack_o); end
        n_chk++; if (bus.s_stb_o !== 5'b0) begin n_err++; $display("FAIL b2b_gap_stb: got %b want 00000", bus.s_stb_o); end
        step();
        n_chk++; if (bus.s_stb_o !== 5'b00001) begin n_err++; $display("FAIL b2b_stb2: got %b want 00001", bus.s_stb_o); end
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL b2b_ack_overlap: got %b want 0", bus.m_ack_o); end
        bus.s_ack_i = 5'b00001;
        bus.s_dat_i[32*SLV_ROM +: 32] = 32'h0000_0C0C;
        step();
        bus.s_ack_i = '0;
        bus.m_cyc_i = 1'b0;
        bus.m_stb_i = 1'b0;
        n_chk++; if (bus.m_ack_o !== 1'b1) begin n_err++; $display("FAIL b2b_ack2: got %b want 1", bus.m_ack_o); end
        n_chk++; if (bus.m_dat_o !== 32'h0000_0C0C) begin n_err++; $display("FAIL b2b_dat2: got %h want 00000c0c", bus.m_dat_o); end
        n_chk++; if (bus.m_err_o !== 1'b0) begin n_err++; $display("FAIL b2b_err: got %b want 0", bus.m_err_o); end
        step();
        n_chk++; if (bus.m_ack_o !== 1'b0) begin n_err++; $display("FAIL b2b_ack2_pulse: got %b want 0", bus.m_ack_o); end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst   = 1'b1;
        bus_idle();
        bus.s_dat_i = '0;
        @(negedge clk);
        test_reset();
        test_clint_read();
        test_clint_write();
        test_decode_miss();
        test_timeout();
        test_abort();
        test_stray_ack();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
